// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Sequencer that fetches program words from a synchronous ROM and
//            drives din/run of the 9-bit multi-cycle processor control unit.
//            Optional EXEC watchdog: define FETCH_DONE_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int INSTRUCTION_WIDTH = 9,
    parameter int ADDR_WIDTH        = 5,
    parameter int START_ADDR        = 0,
    parameter int PROG_LEN          = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         done,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_rd,
    output logic [INSTRUCTION_WIDTH-1:0] din,
    output logic                         run,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic                         busy,
    output logic                         halted
`ifdef FETCH_DONE_WATCHDOG_EN
    ,
    output logic                         timeout
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_I  = 3'd1,
        S_CAP_I = 3'd2,
        S_RD_M  = 3'd3,
        S_CAP_M = 3'd4,
        S_ISSUE = 3'd5,
        S_EXEC  = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    localparam logic [2:0]            c_CMD_MVI  = 3'b001;
    localparam logic [ADDR_WIDTH-1:0] c_START    = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_END_ADDR = ADDR_WIDTH'(START_ADDR + PROG_LEN);
    localparam logic [ADDR_WIDTH-1:0] c_PC_ONE   = ADDR_WIDTH'(1);

    state_t                         r_state;
    logic [ADDR_WIDTH-1:0]          r_pc;
    logic [INSTRUCTION_WIDTH-1:0]   r_instr;
    logic [INSTRUCTION_WIDTH-1:0]   r_imm;
    logic                           r_end_seen;
    logic                           r_mem_rd;
    logic [INSTRUCTION_WIDTH-1:0]   r_din;
    logic                           r_run;
    logic                           r_busy;
    logic                           r_halted;

    logic                           w_rdata_mvi;
    logic                           w_instr_mvi;
    logic [INSTRUCTION_WIDTH-1:0]   w_exec_din;
    logic [ADDR_WIDTH-1:0]          w_pc_inc;
    logic                           w_inc_hits_end;

    assign w_rdata_mvi    = (mem_rdata[INSTRUCTION_WIDTH-1 -: 3] == c_CMD_MVI);
    assign w_instr_mvi    = (r_instr[INSTRUCTION_WIDTH-1 -: 3] == c_CMD_MVI);
    assign w_exec_din     = w_instr_mvi ? r_imm : '0;
    assign w_pc_inc       = r_pc + c_PC_ONE;
    assign w_inc_hits_end = (w_pc_inc == c_END_ADDR);

`ifdef FETCH_DONE_WATCHDOG_EN
    logic [2:0] r_wd_cnt;
    logic       r_timeout;
    assign timeout = r_timeout;
`endif

    // The end flag latches when pc steps onto the end address, so an mvi in the
    // last program word still fetches its immediate (pc then lies past the end).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= c_START;
            r_instr    <= '0;
            r_imm      <= '0;
            r_end_seen <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_din      <= '0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
`ifdef FETCH_DONE_WATCHDOG_EN
            r_wd_cnt   <= 3'd0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_mem_rd <= 1'b0;
            r_run    <= 1'b0;
            r_din    <= '0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state    <= S_RD_I;
                        r_pc       <= c_START;
                        r_end_seen <= 1'b0;
                        r_mem_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
`ifdef FETCH_DONE_WATCHDOG_EN
                        r_timeout  <= 1'b0;
`endif
                    end
                end
                S_RD_I: begin
                    r_state <= S_CAP_I;
                end
                S_CAP_I: begin
                    r_instr <= mem_rdata;
                    r_pc    <= w_pc_inc;
                    if (w_inc_hits_end) begin
                        r_end_seen <= 1'b1;
                    end
                    if (w_rdata_mvi) begin
                        r_state  <= S_RD_M;
                        r_mem_rd <= 1'b1;
                    end else begin
                        r_state <= S_ISSUE;
                        r_run   <= 1'b1;
                        r_din   <= mem_rdata;
                    end
                end
                S_RD_M: begin
                    r_state <= S_CAP_M;
                end
                S_CAP_M: begin
                    r_imm   <= mem_rdata;
                    r_pc    <= w_pc_inc;
                    if (w_inc_hits_end) begin
                        r_end_seen <= 1'b1;
                    end
                    r_state <= S_ISSUE;
                    r_run   <= 1'b1;
                    r_din   <= r_instr;
                end
                S_ISSUE: begin
                    r_state  <= S_EXEC;
                    r_din    <= w_exec_din;
`ifdef FETCH_DONE_WATCHDOG_EN
                    r_wd_cnt <= 3'd0;
`endif
                end
                S_EXEC: begin
                    if (done) begin
                        if (stop || r_end_seen) begin
                            r_state  <= S_HALT;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            r_state  <= S_RD_I;
                            r_mem_rd <= 1'b1;
                        end
                    end else begin
                        r_din <= w_exec_din;
`ifdef FETCH_DONE_WATCHDOG_EN
                        // Seventh silent EXEC cycle gives up on the processor.
                        r_wd_cnt <= r_wd_cnt + 3'd1;
                        if (r_wd_cnt == 3'd6) begin
                            r_state   <= S_HALT;
                            r_busy    <= 1'b0;
                            r_halted  <= 1'b1;
                            r_timeout <= 1'b1;
                            r_din     <= '0;
                        end
`endif
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign mem_rd   = r_mem_rd;
    assign din      = r_din;
    assign run      = r_run;
    assign busy     = r_busy;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit with a ROM, a processor
//            stand-in and a program-walking reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int c_AW    = 5;
    localparam int c_IW    = 9;
    localparam int c_START = 28;
    localparam int c_PLEN  = 6;

    logic              clk = 1'b0;
    logic              rst, start, stop, done;
    logic [c_IW-1:0]   mem_rdata = '0;
    logic [c_AW-1:0]   mem_addr, pc;
    logic              mem_rd, run, busy, halted;
    logic [c_IW-1:0]   din;
`ifdef FETCH_DONE_WATCHDOG_EN
    logic              timeout;
`endif

    logic [c_IW-1:0]   rom [32];
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= rom[mem_addr];
    end

    instr_fetch_unit #(
        .INSTRUCTION_WIDTH (c_IW),
        .ADDR_WIDTH        (c_AW),
        .START_ADDR        (c_START),
        .PROG_LEN          (c_PLEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .done      (done),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .din       (din),
        .run       (run),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
`ifdef FETCH_DONE_WATCHDOG_EN
        ,
        .timeout   (timeout)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: random, 1: no mvi, 2: no mvi except last program word, 3: all mvi
    task automatic fill_rom(input int mode);
        logic [4:0] last;
        int         r;
        for (int i = 0; i < 32; i++) begin
            r = $urandom_range(0, 6);
            case (mode)
                0:       rom[i] = {(r < 2) ? 3'b001 : ((r == 2) ? 3'b000 : 3'(r)), 6'($urandom)};
                3:       rom[i] = {3'b001, 6'($urandom)};
                default: rom[i] = {(r == 0) ? 3'b000 : 3'(r + 1), 6'($urandom)};
            endcase
        end
        last = 5'(c_START + c_PLEN - 1);
        if (mode == 2) rom[last] = {3'b001, 6'($urandom)};
    endtask

    task automatic check_idle_outputs(input string tag, input logic [4:0] exp_pc, input logic exp_halted);
        check({tag, "_halted"}, 32'(halted), 32'(exp_halted));
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_pc"},     32'(pc),     32'(exp_pc));
        check({tag, "_addr"},   32'(mem_addr), 32'(exp_pc));
        check({tag, "_run"},    32'(run),    32'd0);
        check({tag, "_din"},    32'(din),    32'd0);
        check({tag, "_rd"},     32'(mem_rd), 32'd0);
`ifdef FETCH_DONE_WATCHDOG_EN
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
`endif
    endtask

    // Walks the program as the processor sees it: one run per instruction,
    // words consumed counted until the program length is reached or stop hits.
    task automatic exec_program(input int stop_idx);
        logic [4:0] a;
        logic [8:0] ins, imm;
        bit         mvi, fin;
        int         words, idx, lat, hold;
        a = 5'(c_START);
        words = 0;
        idx = 0;
        fin = 0;
        start = 1'b1;
        while (!fin) begin
            ins = rom[a];
            a = a + 5'd1;
            mvi = (ins[8:6] == 3'b001);
            imm = 9'd0;
            if (mvi) begin
                imm = rom[a];
                a = a + 5'd1;
            end
            words += mvi ? 2 : 1;
            lat = 0;
            do begin
                tick();
                lat++;
                start = 1'($urandom_range(0, 1));
                done  = 1'($urandom_range(0, 1));
                stop  = 1'($urandom_range(0, 1));
            end while (!run && lat < 20);
            start = 1'b0;
            done  = 1'b0;
            check("latency",   32'(lat), mvi ? 32'd5 : 32'd3);
            check("issue_din", 32'(din), 32'(ins));
            check("issue_pc",  32'(pc),  32'(a));
            check("issue_busy", 32'(busy), 32'd1);
            hold = $urandom_range(0, 3);
            for (int k = 0; k <= hold; k++) begin
                tick();
                check("exec_din", 32'(din), 32'(imm));
                check("exec_run", 32'(run), 32'd0);
                stop = 1'($urandom_range(0, 1));
            end
            done = 1'b1;
            stop = (idx == stop_idx);
            fin  = stop || (words >= c_PLEN);
            idx++;
            if (fin) begin
                tick();
                done = 1'b0;
                stop = 1'b0;
                check_idle_outputs("halt", a, 1'b1);
                done = 1'b1;
                tick();
                tick();
                done = 1'b0;
                check_idle_outputs("halt_done_ignored", a, 1'b1);
            end
        end
    endtask

    task automatic reset_in_cap_m();
        fill_rom(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("cap_m_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("rst_cap_m", 5'(c_START), 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check_idle_outputs("idle_done_ignored", 5'(c_START), 1'b0);
    endtask

`ifdef FETCH_DONE_WATCHDOG_EN
    task automatic watchdog_run();
        int n;
        fill_rom(1);
        start = 1'b1;
        n = 0;
        do begin
            tick();
            start = 1'b0;
            n++;
        end while (!run && n < 20);
        check("wd_latency", 32'(n), 32'd3);
        n = 0;
        do begin
            tick();
            n++;
        end while (!halted && n < 20);
        check("wd_cycles",  32'(n), 32'd8);
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_busy",    32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wd_clear", 32'(timeout), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        done  = 1'b0;
        fill_rom(0);
        tick();
        tick();
        check_idle_outputs("reset", 5'(c_START), 1'b0);
        rst = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check_idle_outputs("idle", 5'(c_START), 1'b0);

        fill_rom(1);
        exec_program(-1);
        fill_rom(3);
        exec_program(-1);
        fill_rom(2);
        exec_program(-1);
        fill_rom(1);
        exec_program(0);
        exec_program(-1);
        for (int p = 0; p < 8; p++) begin
            fill_rom(0);
            exec_program(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 3)));
        end
        reset_in_cap_m();
        fill_rom(0);
        exec_program(-1);
`ifdef FETCH_DONE_WATCHDOG_EN
        watchdog_run();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "bench time limit expired");
    end

endmodule
`default_nettype wire
